// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch unit, decoder and ALU.
//  - PCSRC_* : next-PC select encodings driven by the decoder
//  - DEF_*   : default reset / interrupt / exception vectors
//  - sext16  : 16-to-32 bit sign extension
package cpu_pkg;

    localparam logic [2:0] PCSRC_SEQ   = 3'b000;
    localparam logic [2:0] PCSRC_BR    = 3'b001;
    localparam logic [2:0] PCSRC_J     = 3'b010;
    localparam logic [2:0] PCSRC_JR    = 3'b011;
    localparam logic [2:0] PCSRC_ILLOP = 3'b100;
    localparam logic [2:0] PCSRC_XADR  = 3'b101;

    localparam logic [31:0] DEF_RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchroniser for an asynchronous level input plus
// rising-edge detector on the synchronised level.
//  clk        in   rising-edge clock
//  reset      in   synchronous, active-high; clears all flops
//  async_in   in   asynchronous level
//  rise_pulse out  one-cycle pulse when the synchronised level goes 0->1
module irq_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STG-1:0] r_sync;
    logic                r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], async_in};
            r_prev <= r_sync[SYNC_STG-1];
        end
    end

    // Edge is taken on the last synchroniser stage, so a held-high line
    // produces exactly one pulse.
    assign rise_pulse = r_sync[SYNC_STG-1] & ~r_prev;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter stage feeding the instruction decoder.
// Holds PC, drives the imem address, selects next PC from the decoder's
// PCSrc, and keeps a sticky interrupt request built from a synchronised
// irq_raw edge.
//
// Optional feature: define PC_INSTRET_CNT_EN to add output InstRet[31:0],
// a retired-instruction counter (+1 per Advance cycle not taking a trap
// vector). Undefined: port and counter are absent.
//
// Ports:
//  clk, reset         clock, synchronous active-high reset
//  irq_raw            asynchronous interrupt line
//  imem_valid         imem_rdata valid for current PC (0 = stall)
//  imem_rdata         instruction at PC
//  PCSrc              next-PC select (seq/br/j/jr/ILLOP/XADR)
//  BranchCond         branch taken
//  JrTarget           register target for jr/jalr
//  imem_addr, PC      current PC
//  Instr              imem_rdata pass-through
//  PC_plus4           {PC[31], PC[30:0]+4}
//  PC_31              supervisor bit
//  IRQ                sticky pending interrupt
//  Advance            = imem_valid
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
    parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC,
    parameter int          SYNC_STG  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_raw,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic [2:0]  PCSrc,
    input  logic        BranchCond,
    input  logic [31:0] JrTarget,
    output logic [31:0] imem_addr,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        PC_31,
    output logic        IRQ,
    output logic        Advance
`ifdef PC_INSTRET_CNT_EN
    ,
    output logic [31:0] InstRet
`endif
);

    logic [31:0] r_pc;
    logic        r_pending;
    logic        w_rise;
    logic [31:0] w_plus4;
    logic [30:0] w_br_off;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_clear;

    irq_sync #(.SYNC_STG(SYNC_STG)) u_irq_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (irq_raw),
        .rise_pulse (w_rise)
    );

    // Supervisor bit is never touched by the +4 carry; low 31 bits wrap.
    assign w_plus4  = {r_pc[31], r_pc[30:0] + 31'd4};
    assign w_br_off = 31'(sext16(imem_rdata[15:0]) << 2);

    always_comb begin
        w_target = w_plus4;
        case (PCSrc)
            PCSRC_SEQ:   w_target = w_plus4;
            PCSRC_BR:    w_target = BranchCond ? {r_pc[31], w_plus4[30:0] + w_br_off} : w_plus4;
            PCSRC_J:     w_target = {r_pc[31], w_plus4[30:28], imem_rdata[25:0], 2'b00};
            // User code cannot raise bit 31 through jr; kernel may clear it.
            PCSRC_JR:    w_target = {JrTarget[31] & r_pc[31], JrTarget[30:0]};
            PCSRC_ILLOP: w_target = ILLOP_VEC;
            default:     w_target = XADR_VEC;
        endcase
        w_next_pc = {w_target[31:2], 2'b00};
    end

    assign w_clear = imem_valid && (PCSrc == PCSRC_ILLOP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_pending <= 1'b0;
        end else begin
            if (imem_valid)
                r_pc <= w_next_pc;
            // A new edge always lands, even in a stall or in the cycle that
            // acknowledges the previous request, so no interrupt is lost.
            if (w_rise)
                r_pending <= 1'b1;
            else if (w_clear)
                r_pending <= 1'b0;
        end
    end

`ifdef PC_INSTRET_CNT_EN
    logic [31:0] r_instret;

    always_ff @(posedge clk) begin
        if (reset)
            r_instret <= '0;
        else if (imem_valid && !PCSrc[2])
            r_instret <= r_instret + 32'd1;
    end

    assign InstRet = r_instret;
`endif

    assign imem_addr = r_pc;
    assign PC        = r_pc;
    assign PC_plus4  = w_plus4;
    assign PC_31     = r_pc[31];
    assign Instr     = imem_rdata;
    assign IRQ       = r_pending;
    assign Advance   = imem_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit. Each step drives one cycle of
// stimulus, pushes the expected {PC, IRQ} to a scoreboard queue, and after
// the clock edge pops and compares against the DUT.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_raw;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [2:0]  PCSrc;
    logic        BranchCond;
    logic [31:0] JrTarget;
    logic [31:0] imem_addr, Instr, PC, PC_plus4;
    logic        PC_31, IRQ, Advance;
`ifdef PC_INSTRET_CNT_EN
    logic [31:0] InstRet;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .irq_raw    (irq_raw),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .PCSrc      (PCSrc),
        .BranchCond (BranchCond),
        .JrTarget   (JrTarget),
        .imem_addr  (imem_addr),
        .Instr      (Instr),
        .PC         (PC),
        .PC_plus4   (PC_plus4),
        .PC_31      (PC_31),
        .IRQ        (IRQ),
        .Advance    (Advance)
`ifdef PC_INSTRET_CNT_EN
        ,
        .InstRet    (InstRet)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push expectation, clock, pop and compare.
    task automatic step(input string tag, input logic [2:0] src, input logic bc,
                        input logic [31:0] ins, input logic [31:0] jr,
                        input logic vld, input logic irq,
                        input logic [31:0] epc, input logic eirq);
        logic [32:0] e;
        PCSrc = src; BranchCond = bc; imem_rdata = ins; JrTarget = jr;
        imem_valid = vld; irq_raw = irq;
        sb_q.push_back({epc, eirq});
        @(posedge clk); #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_pc"}, PC, e[32:1]);
            chk({tag, "_irq"}, {31'd0, IRQ}, {31'd0, e[0]});
        end
    endtask

    initial begin
        reset = 1'b1; irq_raw = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        PCSrc = 3'b000; BranchCond = 1'b0; JrTarget = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_pc", PC, 32'h8000_0000);
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        chk("rst_pc31", {31'd0, PC_31}, 32'd1);
        chk("rst_plus4", PC_plus4, 32'h8000_0004);
        chk("rst_addr", imem_addr, 32'h8000_0000);

        // sequential fetch
        step("seq1", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0004, 0);
        step("seq2", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0008, 0);
        step("seq3", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h8000_000C, 0);

        // kernel leaves via jr; pass-through and Advance
        step("jr_user", 3'b011, 0, 32'h0, 32'h0000_0100, 1, 0, 32'h0000_0100, 0);
        chk("pc31_user", {31'd0, PC_31}, 32'd0);
        imem_rdata = 32'hDEAD_BEEF; imem_valid = 1'b1; #1;
        chk("instr_pass", Instr, 32'hDEAD_BEEF);
        chk("advance", {31'd0, Advance}, 32'd1);

        // branches
        step("br_taken", 3'b001, 1, 32'h0000_FFFE, 32'h0, 1, 0, 32'h0000_00FC, 0);
        step("jr_back", 3'b011, 0, 32'h0, 32'h0000_0100, 1, 0, 32'h0000_0100, 0);
        step("br_not", 3'b001, 0, 32'h0000_FFFE, 32'h0, 1, 0, 32'h0000_0104, 0);

        // jr cannot enter kernel from user mode
        step("jr_nokern", 3'b011, 0, 32'h0, 32'h8000_0040, 1, 0, 32'h0000_0040, 0);
        step("xadr", 3'b101, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0008, 0);
        step("seqk1", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h8000_000C, 0);
        step("seqk2", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0010, 0);
        step("jr_kern", 3'b011, 0, 32'h0, 32'h8000_0040, 1, 0, 32'h8000_0040, 0);

        // wrap of low 31 bits, jump, and 111 -> XADR
        step("jr_edge", 3'b011, 0, 32'h0, 32'h7FFF_FFFC, 1, 0, 32'h7FFF_FFFC, 0);
        step("wrap", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h0000_0000, 0);
        step("jump", 3'b010, 0, 32'h03FF_FFFF, 32'h0, 1, 0, 32'h0FFF_FFFC, 0);
        step("src111", 3'b111, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0008, 0);

        // interrupt latency, stall hold, acknowledge
        step("jr_200", 3'b011, 0, 32'h0, 32'h0000_0200, 1, 0, 32'h0000_0200, 0);
        step("irq_c1", 3'b000, 0, 32'h0, 32'h0, 1, 1, 32'h0000_0204, 0);
        step("irq_c2", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h0000_0208, 0);
        step("irq_c3", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h0000_020C, 1);
        step("stall1", 3'b011, 0, 32'h0, 32'h0000_0400, 0, 0, 32'h0000_020C, 1);
        step("stall2", 3'b100, 0, 32'h0, 32'h0, 0, 0, 32'h0000_020C, 1);
        step("illop", 3'b100, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0004, 0);

        // new edge in the clearing cycle keeps IRQ; held level does not re-set
        step("jr_300", 3'b011, 0, 32'h0, 32'h0000_0300, 1, 0, 32'h0000_0300, 0);
        step("race_c1", 3'b000, 0, 32'h0, 32'h0, 1, 1, 32'h0000_0304, 0);
        step("race_c2", 3'b000, 0, 32'h0, 32'h0, 1, 1, 32'h0000_0308, 0);
        step("race_clr", 3'b100, 0, 32'h0, 32'h0, 1, 1, 32'h8000_0004, 1);
        step("level_clr", 3'b100, 0, 32'h0, 32'h0, 1, 1, 32'h8000_0004, 0);
        step("level_hold", 3'b000, 0, 32'h0, 32'h0, 1, 1, 32'h8000_0008, 0);

        // reset while PC=0000_0200 and IRQ=1
        step("jr_1f4", 3'b011, 0, 32'h0, 32'h0000_01F4, 1, 0, 32'h0000_01F4, 0);
        step("r_c1", 3'b000, 0, 32'h0, 32'h0, 1, 1, 32'h0000_01F8, 0);
        step("r_c2", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h0000_01FC, 0);
        step("r_c3", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h0000_0200, 1);
        reset = 1'b1;
        step("reset_mid", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0000, 0);
`ifdef PC_INSTRET_CNT_EN
        chk("instret_rst", InstRet, 32'd0);
`endif
        reset = 1'b0;
        step("post_rst", 3'b000, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0004, 0);
`ifdef PC_INSTRET_CNT_EN
        chk("instret_cnt", InstRet, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
